// File: rtl/round_turn_sequencer_pkg.sv
// Shared types for the round/turn game sequencer: FSM states, player id, winner codes.
package round_turn_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        TURN      = 3'd2,
        EVAL      = 3'd3,
        ROUND_END = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic {
        PLAYER1 = 1'b0,
        PLAYER2 = 1'b1
    } player_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [1:0] decode_winner(input logic [3:0] s1, input logic [3:0] s2);
        if (s1 > s2)      return WIN_P1;
        else if (s2 > s1) return WIN_P2;
        else              return WIN_TIE;
    endfunction

endpackage

// File: rtl/round_turn_sequencer_if.sv
// Move/evaluation handshake between the sequencer (master) and front end / board datapath (slave).
interface round_turn_sequencer_if;
    logic move_valid;
    logic move_ready;
    logic eval_done;
    logic eval_win;
    logic eval_full;
    logic board_clear;

    modport master (
        input  move_valid, eval_done, eval_win, eval_full,
        output move_ready, board_clear
    );

    modport slave (
        output move_valid, eval_done, eval_win, eval_full,
        input  move_ready, board_clear
    );
endinterface

// File: rtl/round_turn_sequencer_turn_timer.sv
// Loadable saturating down-counter; expire flags the tick that consumes the last count.
module turn_timer #(
    parameter int         W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expire
);

    always_ff @(posedge Clk) begin
        if (Reset)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && (count != '0))
            count <= count - 1'b1;
    end

    assign expire = tick && (count == W'(1));

endmodule

// File: rtl/round_turn_sequencer.sv
// Game controller: rounds, alternating timed turns, move handshake, scoring, match winner.
// Optional freeze on pause enabled by defining ROUND_SEQ_PAUSE_EN.
module round_turn_sequencer
    import round_turn_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS   = 3,
    parameter int TURN_TICKS   = 600,
    parameter int RESULT_TICKS = 120,
    parameter int MOVES_MAX    = 9
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              start,
    input  logic                              frame_tick,
    input  logic                              pause,
    round_turn_sequencer_if.master            bus,
    output logic                              cur_player,
    output logic                              display_board1,
    output logic                              display_board2,
    output logic [3:0]                        round,
    output logic [3:0]                        score1,
    output logic [3:0]                        score2,
    output logic [$clog2(TURN_TICKS+1)-1:0]   timer,
    output logic                              timeout,
    output logic                              round_over,
    output logic                              game_done,
    output logic [1:0]                        winner
);

    localparam int              TW         = $clog2(TURN_TICKS + 1);
    localparam int              RW         = $clog2(RESULT_TICKS + 1);
    localparam logic [TW-1:0]   TURN_LOAD  = TW'(TURN_TICKS);
    localparam logic [RW-1:0]   RES_LOAD   = RW'(RESULT_TICKS);
    localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0]      MOVE_LIMIT = 4'(MOVES_MAX);

    state_t     state, state_n;
    player_t    player, player_n;
    logic [3:0] round_q, round_n;
    logic [3:0] s1_q, s1_n, s2_q, s2_n;
    logic [3:0] mcnt, mcnt_n;
    logic       start_q;
    logic       timeout_q, timeout_n;
    logic       rover_q, rover_n;

    logic       hold;
    logic       start_edge, accept;
    logic       t_load, t_tick, t_expire;
    logic       r_load, r_tick, r_expire;
    logic [RW-1:0] r_count;

`ifdef ROUND_SEQ_PAUSE_EN
    assign hold = pause;
`else
    // pause pin kept for pin compatibility; it has no effect in this build
    assign hold = pause & 1'b0;
`endif

    assign start_edge = start & ~start_q;
    assign accept     = bus.move_valid & bus.move_ready;

    // A move accepted on the expiring tick wins: the tick never reaches the timer
    assign t_tick = (state == TURN) & frame_tick & ~hold & ~accept;
    assign r_load = (state != ROUND_END);
    assign r_tick = (state == ROUND_END) & frame_tick & ~hold & (r_count != '0);

    turn_timer #(.W(TW), .RST_VAL(TURN_LOAD)) u_turn_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (t_load),
        .load_val (TURN_LOAD),
        .tick     (t_tick),
        .count    (timer),
        .expire   (t_expire)
    );

    turn_timer #(.W(RW), .RST_VAL(RES_LOAD)) u_result_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (r_load),
        .load_val (RES_LOAD),
        .tick     (r_tick),
        .count    (r_count),
        .expire   (r_expire)
    );

    always_comb begin
        state_n   = state;
        player_n  = player;
        round_n   = round_q;
        s1_n      = s1_q;
        s2_n      = s2_q;
        mcnt_n    = mcnt;
        t_load    = 1'b0;
        timeout_n = 1'b0;
        rover_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    round_n = 4'd1;
                    s1_n    = 4'd0;
                    s2_n    = 4'd0;
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                mcnt_n   = 4'd0;
                t_load   = 1'b1;
                player_n = round_q[0] ? PLAYER1 : PLAYER2;
                state_n  = TURN;
            end
            TURN: begin
                if (accept) begin
                    mcnt_n  = sat_inc4(mcnt);
                    state_n = EVAL;
                end else if (t_expire) begin
                    timeout_n = 1'b1;
                    player_n  = (player == PLAYER1) ? PLAYER2 : PLAYER1;
                    t_load    = 1'b1;
                end
            end
            EVAL: begin
                if (bus.eval_done) begin
                    if (bus.eval_win) begin
                        if (player == PLAYER1) s1_n = sat_inc4(s1_q);
                        else                   s2_n = sat_inc4(s2_q);
                        rover_n = 1'b1;
                        state_n = ROUND_END;
                    end else if (bus.eval_full || (mcnt == MOVE_LIMIT)) begin
                        rover_n = 1'b1;
                        state_n = ROUND_END;
                    end else begin
                        player_n = (player == PLAYER1) ? PLAYER2 : PLAYER1;
                        t_load   = 1'b1;
                        state_n  = TURN;
                    end
                end
            end
            ROUND_END: begin
                if (r_expire) begin
                    if (round_q == LAST_ROUND) begin
                        state_n = DONE;
                    end else begin
                        round_n = sat_inc4(round_q);
                        state_n = CLEAR;
                    end
                end
            end
            DONE: begin
                if (start_edge) begin
                    round_n = 4'd1;
                    s1_n    = 4'd0;
                    s2_n    = 4'd0;
                    state_n = CLEAR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            player    <= PLAYER1;
            round_q   <= 4'd0;
            s1_q      <= 4'd0;
            s2_q      <= 4'd0;
            mcnt      <= 4'd0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            rover_q   <= 1'b0;
        end else begin
            state     <= state_n;
            player    <= player_n;
            round_q   <= round_n;
            s1_q      <= s1_n;
            s2_q      <= s2_n;
            mcnt      <= mcnt_n;
            start_q   <= start;
            timeout_q <= timeout_n;
            rover_q   <= rover_n;
        end
    end

    assign bus.move_ready  = (state == TURN) & ~hold;
    assign bus.board_clear = (state == CLEAR);
    assign cur_player      = (player == PLAYER2);
    assign display_board1  = ((state == TURN) & (player == PLAYER1)) | (state == ROUND_END);
    assign display_board2  = ((state == TURN) & (player == PLAYER2)) | (state == ROUND_END);
    assign round           = round_q;
    assign score1          = s1_q;
    assign score2          = s2_q;
    assign timeout         = timeout_q;
    assign round_over      = rover_q;
    assign game_done       = (state == DONE);
    assign winner          = (state == DONE) ? decode_winner(s1_q, s2_q) : WIN_NONE;

endmodule

// File: doc/round_turn_sequencer.md
Name: round_turn_sequencer

Overview:
- Top-level game controller that sequences a multi-round, two-player board game.
- Starts rounds, clears the board, alternates player turns with a per-turn timeout, and hands each move to the board-evaluation datapath over a valid/ready handshake.
- Keeps scores and reports the match winner.
- Sits between the input/keyboard front end and the board datapath/renderer.

Parameters:
- NUM_ROUNDS, 3: rounds per match (1..15).
- TURN_TICKS, 600: frame ticks allowed per turn (10 s at 60 Hz).
- RESULT_TICKS, 120: frame ticks the round result is held on screen.
- MOVES_MAX, 9: accepted moves that force a draw.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  level from button; rising edge detected internally.
- frame_tick  in  1  one-cycle pulse per video frame.
- pause  in  1  freeze request (used only with the feature macro).
- move_valid  in  1  front end offers a move.
- move_ready  out  1  sequencer accepts a move this cycle.
- eval_done  in  1  one-cycle pulse: board finished evaluating the last move.
- eval_win  in  1  qualified by eval_done: last move wins.
- eval_full  in  1  qualified by eval_done: board full.
- board_clear  out  1  one-cycle pulse that clears the board.
- cur_player  out  1  0 = player 1, 1 = player 2.
- display_board1  out  1  highlight player-1 panel.
- display_board2  out  1  highlight player-2 panel.
- round  out  4  current round, 1..NUM_ROUNDS; 0 when idle.
- score1  out  4  player-1 round wins, saturating at 15.
- score2  out  4  player-2 round wins, saturating at 15.
- timer  out  $clog2(TURN_TICKS+1)  ticks remaining in the current turn.
- timeout  out  1  one-cycle pulse on turn forfeit.
- round_over  out  1  one-cycle pulse on entry to ROUND_END.
- game_done  out  1  high in DONE.
- winner  out  2  01 = player 1, 10 = player 2, 11 = tie, 00 when not DONE.

Behaviour:
- Reset:
  - Next edge forces IDLE from any state, including mid-turn or mid-eval.
  - All outputs 0, except timer = TURN_TICKS.
  - Internal start_q = 0 and move_count = 0.
- IDLE:
  - On a start rising edge (start & ~start_q): round <= 1, go to CLEAR.
  - start edges in CLEAR, TURN, EVAL and ROUND_END are ignored.
- CLEAR (exactly 1 cycle):
  - board_clear = 1.
  - move_count <= 0, timer <= TURN_TICKS.
  - cur_player <= ~round[0] (odd rounds: player 1 starts; even rounds: player 2).
  - Go to TURN.
- TURN:
  - move_ready = 1.
  - display_boardN = 1 for the active player only.
  - On move_valid & move_ready: move_count++, go to EVAL; timer holds its value.
  - Otherwise each frame_tick decrements timer.
  - A tick while timer == 1 is a forfeit: timeout pulse, cur_player toggles, timer <= TURN_TICKS, stay in TURN.
  - If a handshake and the expiring tick occur in the same cycle, the move wins; no timeout.
- EVAL:
  - move_ready = 0; timer frozen.
  - Wait for eval_done.
  - eval_win: increment the active player's score (saturating), go to ROUND_END.
  - Else eval_full or move_count == MOVES_MAX: draw, go to ROUND_END.
  - Else toggle cur_player, timer <= TURN_TICKS, go to TURN.
- ROUND_END:
  - round_over pulses on entry; both display_board outputs = 1.
  - Count RESULT_TICKS frame ticks.
  - Then: if round == NUM_ROUNDS go to DONE, else round++ and go to CLEAR.
- DONE:
  - game_done = 1; winner decoded from score1 vs score2.
  - A start rising edge clears scores, sets round <= 1, goes to CLEAR.
- Handshake:
  - move_ready is a registered-state decode with no combinational path from move_valid.
  - Exactly one move is accepted per handshake cycle.
- Widths:
  - move_count is 4 bits.
  - The ROUND_END counter is $clog2(RESULT_TICKS+1) bits.
  - No counter wraps; all stop at their limit.

Optional Feature:
- ROUND_SEQ_PAUSE_EN defined:
  - pause high in TURN forces move_ready = 0 and ignores frame_tick, freezing timer.
  - pause high in ROUND_END also freezes the result counter.
  - EVAL is unaffected.
- Undefined: the pause port exists but is ignored.

Decomposition:
- game_pkg holds:
  - state enum {IDLE, CLEAR, TURN, EVAL, ROUND_END, DONE}.
  - player_t.
  - winner codes WIN_NONE, WIN_P1, WIN_P2, WIN_TIE.
- One sub-module, turn_timer: loadable down-counter with tick enable, reload, and expire flag. It is reused for the ROUND_END hold.

Test Plan (bench params: NUM_ROUNDS=2, TURN_TICKS=4, RESULT_TICKS=2, MOVES_MAX=9):
- Reset then start pulse -> one cycle later board_clear=1 for 1 cycle, round=1, cur_player=0, move_ready=1, timer=4.
- Move handshake, then eval_done with eval_win=1 -> score1=1, round_over pulse; after 2 ticks round=2, board_clear pulses, cur_player=1.
- In TURN, 4 frame_ticks with no move -> timeout pulse on the 4th tick, cur_player toggles, timer=4. Then move_valid and the 4th tick in the same cycle -> EVAL entered, no timeout.
- 9 accepted moves, each eval_done with win=0 and full=0 -> the 9th goes to ROUND_END as a draw, scores unchanged.
- Finish round 2 with player 2 winning after player 1 won round 1 -> game_done=1, winner=11. Then start edge -> scores=0, round=1.
- Assert Reset during EVAL -> next cycle IDLE, move_ready=0, round=0, scores=0. A late eval_done is ignored.
